// File: rtl/idu_rf_pkg.sv
// Shared default constants for the parametrised register-read stage.
package idu_rf_pkg;

  localparam int XLEN_D    = 64;
  localparam int PREG_W_D  = 6;
  localparam int IID_W_D   = 5;
  localparam int FWD_NUM_D = 8;

endpackage

// File: rtl/idu_rf_fwd_sel.sv
// Priority bypass match-and-select for one source operand; lowest port index wins.
module idu_rf_fwd_sel
  import idu_rf_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int PREG_W  = PREG_W_D,
  parameter int FWD_NUM = FWD_NUM_D
) (
  input  logic                      psrc_vld,
  input  logic [PREG_W-1:0]         psrc,
  input  logic [FWD_NUM-1:0]        fwd_vld,
  input  logic [FWD_NUM*PREG_W-1:0] fwd_preg,
  input  logic [FWD_NUM*XLEN-1:0]   fwd_result,
  output logic                      hit,
  output logic [XLEN-1:0]           value
);

  logic [FWD_NUM-1:0] match;

  generate
    for (genvar gi = 0; gi < FWD_NUM; gi++) begin : g_match
      assign match[gi] = fwd_vld[gi] & (fwd_preg[gi*PREG_W +: PREG_W] == psrc);
    end
  endgenerate

  // Scan from the highest index down so the lowest matching port is the last writer.
  always_comb begin
    hit   = psrc_vld & (|match);
    value = '0;
    for (int j = FWD_NUM - 1; j >= 0; j--) begin
      if (match[j]) begin
        value = fwd_result[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/idu_rf_pipex.sv
// Register-read stage for one issue pipe: uop latch, regfile read, bypass resolve, EX handshake.
// Optional bypass capture during stalls is enabled by defining RF_PIPE_FWD_CAPTURE_EN.
module idu_rf_pipex
  import idu_rf_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int PREG_W  = PREG_W_D,
  parameter int IID_W   = IID_W_D,
  parameter int FWD_NUM = FWD_NUM_D
) (
  input  logic                      clk,
  input  logic                      rst_clk,
  input  logic                      rtu_global_flush,
  input  logic                      idu_rf_vld,
  output logic                      idu_rf_rdy,
  input  logic [IID_W-1:0]          idu_rf_iid,
  input  logic [6:0]                idu_rf_opcode,
  input  logic [6:0]                idu_rf_funct7,
  input  logic [2:0]                idu_rf_funct3,
  input  logic [XLEN-1:0]           idu_rf_pc,
  input  logic                      idu_rf_psrc1_vld,
  input  logic [PREG_W-1:0]         idu_rf_psrc1,
  input  logic                      idu_rf_psrc2_vld,
  input  logic [PREG_W-1:0]         idu_rf_psrc2,
  input  logic                      idu_rf_pdst_vld,
  input  logic [PREG_W-1:0]         idu_rf_pdst,
  input  logic                      idu_rf_imm_vld,
  input  logic [XLEN-1:0]           idu_rf_imm,
  input  logic [FWD_NUM-1:0]        fwd_vld,
  input  logic [FWD_NUM*PREG_W-1:0] fwd_preg,
  input  logic [FWD_NUM*XLEN-1:0]   fwd_result,
  output logic                      x_rf_preg_psrc1_vld,
  output logic [PREG_W-1:0]         x_rf_preg_psrc1,
  output logic                      x_rf_preg_psrc2_vld,
  output logic [PREG_W-1:0]         x_rf_preg_psrc2,
  input  logic [XLEN-1:0]           x_rf_psrc1_value,
  input  logic [XLEN-1:0]           x_rf_psrc2_value,
  input  logic                      ex_rf_rdy,
  output logic                      pipe_vld,
  output logic [IID_W-1:0]          pipe_iid,
  output logic [6:0]                pipe_opcode,
  output logic [6:0]                pipe_funct7,
  output logic [2:0]                pipe_funct3,
  output logic [XLEN-1:0]           pipe_pc,
  output logic                      pipe_psrc1_vld,
  output logic [XLEN-1:0]           pipe_psrc1_value,
  output logic                      pipe_psrc2_vld,
  output logic [XLEN-1:0]           pipe_psrc2_value,
  output logic                      pipe_pdst_vld,
  output logic [PREG_W-1:0]         pipe_pdst,
  output logic                      pipe_imm_vld,
  output logic [XLEN-1:0]           pipe_imm
);

  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic              psrc1_vld;
    logic [PREG_W-1:0] psrc1;
    logic              psrc2_vld;
    logic [PREG_W-1:0] psrc2;
    logic              pdst_vld;
    logic [PREG_W-1:0] pdst;
    logic              imm_vld;
    logic [XLEN-1:0]   imm;
  } uop_t;

  logic pipe_vld_reg, pipe_vld_next;
  uop_t uop_reg, uop_next, uop_in;
  logic accept, issue;

  assign idu_rf_rdy = ~pipe_vld_reg | ex_rf_rdy;
  assign accept     = idu_rf_vld & idu_rf_rdy;
  assign issue      = pipe_vld_reg & ex_rf_rdy;

  always_comb begin
    uop_in           = '0;
    uop_in.iid       = idu_rf_iid;
    uop_in.opcode    = idu_rf_opcode;
    uop_in.funct7    = idu_rf_funct7;
    uop_in.funct3    = idu_rf_funct3;
    uop_in.pc        = idu_rf_pc;
    uop_in.psrc1_vld = idu_rf_psrc1_vld;
    uop_in.psrc1     = idu_rf_psrc1;
    uop_in.psrc2_vld = idu_rf_psrc2_vld;
    uop_in.psrc2     = idu_rf_psrc2;
    uop_in.pdst_vld  = idu_rf_pdst_vld;
    uop_in.pdst      = idu_rf_pdst;
    uop_in.imm_vld   = idu_rf_imm_vld;
    uop_in.imm       = idu_rf_imm;
  end

  // Flush beats accept; an issue without a replacement drains the payload back to zero.
  always_comb begin
    pipe_vld_next = pipe_vld_reg;
    uop_next      = uop_reg;
    if (rtu_global_flush) begin
      pipe_vld_next = 1'b0;
      uop_next      = '0;
    end else if (accept) begin
      pipe_vld_next = 1'b1;
      uop_next      = uop_in;
    end else if (issue) begin
      pipe_vld_next = 1'b0;
      uop_next      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      pipe_vld_reg <= 1'b0;
      uop_reg      <= '0;
    end else begin
      pipe_vld_reg <= pipe_vld_next;
      uop_reg      <= uop_next;
    end
  end

  logic [1:0]        src_vld;
  logic [PREG_W-1:0] src_preg [2];
  logic [XLEN-1:0]   rf_val   [2];
  logic [1:0]        hit;
  logic [XLEN-1:0]   fwd_val  [2];
  logic [XLEN-1:0]   op_val   [2];

  assign src_vld     = {uop_reg.psrc2_vld, uop_reg.psrc1_vld};
  assign src_preg[0] = uop_reg.psrc1;
  assign src_preg[1] = uop_reg.psrc2;
  assign rf_val[0]   = x_rf_psrc1_value;
  assign rf_val[1]   = x_rf_psrc2_value;

`ifdef RF_PIPE_FWD_CAPTURE_EN
  logic            hold;
  logic [1:0]      cap_vld_reg, cap_vld_next;
  logic [XLEN-1:0] cap_val_reg [2];
  logic [XLEN-1:0] cap_val_next [2];

  assign hold = pipe_vld_reg & ~ex_rf_rdy;

  // A bypass seen during a stall is held so the operand survives the port going idle.
  always_comb begin
    cap_vld_next = cap_vld_reg;
    cap_val_next = cap_val_reg;
    if (rtu_global_flush | accept | issue) begin
      cap_vld_next = '0;
      cap_val_next = '{default: '0};
    end else if (hold) begin
      for (int k = 0; k < 2; k++) begin
        if (src_vld[k] & ~cap_vld_reg[k] & hit[k]) begin
          cap_vld_next[k] = 1'b1;
          cap_val_next[k] = fwd_val[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      cap_vld_reg <= '0;
      cap_val_reg <= '{default: '0};
    end else begin
      cap_vld_reg <= cap_vld_next;
      cap_val_reg <= cap_val_next;
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      idu_rf_fwd_sel #(
        .XLEN    (XLEN),
        .PREG_W  (PREG_W),
        .FWD_NUM (FWD_NUM)
      ) u_fwd_sel (
        .psrc_vld   (src_vld[gi]),
        .psrc       (src_preg[gi]),
        .fwd_vld    (fwd_vld),
        .fwd_preg   (fwd_preg),
        .fwd_result (fwd_result),
        .hit        (hit[gi]),
        .value      (fwd_val[gi])
      );
`ifdef RF_PIPE_FWD_CAPTURE_EN
      assign op_val[gi] = cap_vld_reg[gi] ? cap_val_reg[gi] :
                          hit[gi]         ? fwd_val[gi]     : rf_val[gi];
`else
      assign op_val[gi] = hit[gi] ? fwd_val[gi] : rf_val[gi];
`endif
    end
  endgenerate

  assign x_rf_preg_psrc1_vld = uop_reg.psrc1_vld;
  assign x_rf_preg_psrc1     = uop_reg.psrc1;
  assign x_rf_preg_psrc2_vld = uop_reg.psrc2_vld;
  assign x_rf_preg_psrc2     = uop_reg.psrc2;

  assign pipe_vld         = pipe_vld_reg;
  assign pipe_iid         = uop_reg.iid;
  assign pipe_opcode      = uop_reg.opcode;
  assign pipe_funct7      = uop_reg.funct7;
  assign pipe_funct3      = uop_reg.funct3;
  assign pipe_pc          = uop_reg.pc;
  assign pipe_psrc1_vld   = uop_reg.psrc1_vld;
  assign pipe_psrc1_value = op_val[0];
  assign pipe_psrc2_vld   = uop_reg.psrc2_vld;
  assign pipe_psrc2_value = op_val[1];
  assign pipe_pdst_vld    = uop_reg.pdst_vld;
  assign pipe_pdst        = uop_reg.pdst;
  assign pipe_imm_vld     = uop_reg.imm_vld;
  assign pipe_imm         = uop_reg.imm;

endmodule

// File: tb/tb_idu_rf_pipex.sv
// Randomised bench for idu_rf_pipex against a behavioural stage model, plus directed literal checks.
module tb_idu_rf_pipex;

  localparam int XL = 64;
  localparam int PW = 6;
  localparam int IW = 5;
  localparam int FN = 8;
`ifdef RF_PIPE_FWD_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_clk;
  logic rtu_global_flush, idu_rf_vld, idu_rf_rdy;
  logic [IW-1:0] idu_rf_iid;
  logic [6:0] idu_rf_opcode, idu_rf_funct7;
  logic [2:0] idu_rf_funct3;
  logic [XL-1:0] idu_rf_pc, idu_rf_imm;
  logic idu_rf_psrc1_vld, idu_rf_psrc2_vld, idu_rf_pdst_vld, idu_rf_imm_vld;
  logic [PW-1:0] idu_rf_psrc1, idu_rf_psrc2, idu_rf_pdst;
  logic [FN-1:0] fwd_vld;
  logic [FN*PW-1:0] fwd_preg;
  logic [FN*XL-1:0] fwd_result;
  logic x_rf_preg_psrc1_vld, x_rf_preg_psrc2_vld;
  logic [PW-1:0] x_rf_preg_psrc1, x_rf_preg_psrc2;
  logic [XL-1:0] x_rf_psrc1_value, x_rf_psrc2_value;
  logic ex_rf_rdy;
  logic pipe_vld;
  logic [IW-1:0] pipe_iid;
  logic [6:0] pipe_opcode, pipe_funct7;
  logic [2:0] pipe_funct3;
  logic [XL-1:0] pipe_pc, pipe_psrc1_value, pipe_psrc2_value, pipe_imm;
  logic pipe_psrc1_vld, pipe_psrc2_vld, pipe_pdst_vld, pipe_imm_vld;
  logic [PW-1:0] pipe_pdst;

  always #5 clk = ~clk;

  idu_rf_pipex dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
    .idu_rf_vld(idu_rf_vld), .idu_rf_rdy(idu_rf_rdy),
    .idu_rf_iid(idu_rf_iid), .idu_rf_opcode(idu_rf_opcode), .idu_rf_funct7(idu_rf_funct7),
    .idu_rf_funct3(idu_rf_funct3), .idu_rf_pc(idu_rf_pc),
    .idu_rf_psrc1_vld(idu_rf_psrc1_vld), .idu_rf_psrc1(idu_rf_psrc1),
    .idu_rf_psrc2_vld(idu_rf_psrc2_vld), .idu_rf_psrc2(idu_rf_psrc2),
    .idu_rf_pdst_vld(idu_rf_pdst_vld), .idu_rf_pdst(idu_rf_pdst),
    .idu_rf_imm_vld(idu_rf_imm_vld), .idu_rf_imm(idu_rf_imm),
    .fwd_vld(fwd_vld), .fwd_preg(fwd_preg), .fwd_result(fwd_result),
    .x_rf_preg_psrc1_vld(x_rf_preg_psrc1_vld), .x_rf_preg_psrc1(x_rf_preg_psrc1),
    .x_rf_preg_psrc2_vld(x_rf_preg_psrc2_vld), .x_rf_preg_psrc2(x_rf_preg_psrc2),
    .x_rf_psrc1_value(x_rf_psrc1_value), .x_rf_psrc2_value(x_rf_psrc2_value),
    .ex_rf_rdy(ex_rf_rdy),
    .pipe_vld(pipe_vld), .pipe_iid(pipe_iid), .pipe_opcode(pipe_opcode),
    .pipe_funct7(pipe_funct7), .pipe_funct3(pipe_funct3), .pipe_pc(pipe_pc),
    .pipe_psrc1_vld(pipe_psrc1_vld), .pipe_psrc1_value(pipe_psrc1_value),
    .pipe_psrc2_vld(pipe_psrc2_vld), .pipe_psrc2_value(pipe_psrc2_value),
    .pipe_pdst_vld(pipe_pdst_vld), .pipe_pdst(pipe_pdst),
    .pipe_imm_vld(pipe_imm_vld), .pipe_imm(pipe_imm)
  );

  typedef struct packed {
    logic [IW-1:0] iid;
    logic [6:0]    opcode;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic [XL-1:0] pc;
    logic          s1v;
    logic [PW-1:0] s1;
    logic          s2v;
    logic [PW-1:0] s2;
    logic          dv;
    logic [PW-1:0] d;
    logic          iv;
    logic [XL-1:0] imm;
  } uop_t;

  int n_vec = 0;
  int n_fail = 0;

  // Behavioural model of the stage: what EX should currently see.
  logic          m_vld;
  uop_t          m_uop;
  logic          m_cap_vld [2];
  logic [XL-1:0] m_cap_val [2];

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic uop_t cur_in();
    uop_t u;
    u.iid = idu_rf_iid;   u.opcode = idu_rf_opcode; u.funct7 = idu_rf_funct7;
    u.funct3 = idu_rf_funct3; u.pc = idu_rf_pc;
    u.s1v = idu_rf_psrc1_vld; u.s1 = idu_rf_psrc1;
    u.s2v = idu_rf_psrc2_vld; u.s2 = idu_rf_psrc2;
    u.dv = idu_rf_pdst_vld; u.d = idu_rf_pdst;
    u.iv = idu_rf_imm_vld; u.imm = idu_rf_imm;
    return u;
  endfunction

  // First bypass port (lowest index) carrying the requested tag.
  function automatic logic fwd_lookup(input logic [PW-1:0] tag, output logic [XL-1:0] val);
    val = '0;
    for (int j = 0; j < FN; j++) begin
      if (fwd_vld[j] && fwd_preg[j*PW +: PW] == tag) begin
        val = fwd_result[j*XL +: XL];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [XL-1:0] exp_op(input int k);
    logic sv;
    logic [PW-1:0] s;
    logic [XL-1:0] v;
    sv = (k == 0) ? m_uop.s1v : m_uop.s2v;
    s  = (k == 0) ? m_uop.s1 : m_uop.s2;
    if (m_cap_vld[k]) return m_cap_val[k];
    if (sv && fwd_lookup(s, v)) return v;
    return (k == 0) ? x_rf_psrc1_value : x_rf_psrc2_value;
  endfunction

  always @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      m_vld <= 1'b0; m_uop <= '0;
      for (int k = 0; k < 2; k++) begin m_cap_vld[k] <= 1'b0; m_cap_val[k] <= '0; end
    end else if (rtu_global_flush) begin
      m_vld <= 1'b0; m_uop <= '0;
      for (int k = 0; k < 2; k++) begin m_cap_vld[k] <= 1'b0; m_cap_val[k] <= '0; end
    end else if (idu_rf_vld && (!m_vld || ex_rf_rdy)) begin
      m_vld <= 1'b1; m_uop <= cur_in();
      for (int k = 0; k < 2; k++) begin m_cap_vld[k] <= 1'b0; m_cap_val[k] <= '0; end
    end else if (m_vld && ex_rf_rdy) begin
      m_vld <= 1'b0; m_uop <= '0;
      for (int k = 0; k < 2; k++) begin m_cap_vld[k] <= 1'b0; m_cap_val[k] <= '0; end
    end else if (m_vld && CAP) begin
      for (int k = 0; k < 2; k++) begin
        logic [XL-1:0] v;
        logic sv;
        sv = (k == 0) ? m_uop.s1v : m_uop.s2v;
        if (sv && !m_cap_vld[k] && fwd_lookup((k == 0) ? m_uop.s1 : m_uop.s2, v)) begin
          m_cap_vld[k] <= 1'b1;
          m_cap_val[k] <= v;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("pipe_vld", {63'd0, pipe_vld}, {63'd0, m_vld});
    chk("idu_rf_rdy", {63'd0, idu_rf_rdy}, {63'd0, !m_vld || ex_rf_rdy});
    chk("pipe_iid", XL'(pipe_iid), XL'(m_uop.iid));
    chk("pipe_opcode", XL'(pipe_opcode), XL'(m_uop.opcode));
    chk("pipe_funct7", XL'(pipe_funct7), XL'(m_uop.funct7));
    chk("pipe_funct3", XL'(pipe_funct3), XL'(m_uop.funct3));
    chk("pipe_pc", pipe_pc, m_uop.pc);
    chk("rf_psrc1_vld", {63'd0, x_rf_preg_psrc1_vld}, {63'd0, m_uop.s1v});
    chk("rf_psrc1", XL'(x_rf_preg_psrc1), XL'(m_uop.s1));
    chk("rf_psrc2_vld", {63'd0, x_rf_preg_psrc2_vld}, {63'd0, m_uop.s2v});
    chk("rf_psrc2", XL'(x_rf_preg_psrc2), XL'(m_uop.s2));
    chk("pipe_psrc1_vld", {63'd0, pipe_psrc1_vld}, {63'd0, m_uop.s1v});
    chk("pipe_psrc2_vld", {63'd0, pipe_psrc2_vld}, {63'd0, m_uop.s2v});
    chk("psrc1_value", pipe_psrc1_value, exp_op(0));
    chk("psrc2_value", pipe_psrc2_value, exp_op(1));
    chk("pipe_pdst_vld", {63'd0, pipe_pdst_vld}, {63'd0, m_uop.dv});
    chk("pipe_pdst", XL'(pipe_pdst), XL'(m_uop.d));
    chk("pipe_imm_vld", {63'd0, pipe_imm_vld}, {63'd0, m_uop.iv});
    chk("pipe_imm", pipe_imm, m_uop.imm);
  end

  task automatic set_uop(input logic [IW-1:0] iid, input logic s1v, input logic [PW-1:0] s1,
                         input logic s2v, input logic [PW-1:0] s2, input logic [XL-1:0] pc);
    idu_rf_iid = iid; idu_rf_opcode = 7'h33; idu_rf_funct7 = 7'h20; idu_rf_funct3 = 3'd5;
    idu_rf_pc = pc; idu_rf_psrc1_vld = s1v; idu_rf_psrc1 = s1;
    idu_rf_psrc2_vld = s2v; idu_rf_psrc2 = s2;
    idu_rf_pdst_vld = 1'b1; idu_rf_pdst = 6'd20; idu_rf_imm_vld = 1'b1; idu_rf_imm = 64'h1234;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int j, input logic [PW-1:0] tag, input logic [XL-1:0] val);
    fwd_preg[j*PW +: PW] = tag;
    fwd_result[j*XL +: XL] = val;
  endtask

  initial begin
    rst_clk = 1'b0; rtu_global_flush = 1'b0; idu_rf_vld = 1'b0; ex_rf_rdy = 1'b0;
    set_uop('0, 1'b0, '0, 1'b0, '0, '0);
    fwd_vld = '0; fwd_preg = '0; fwd_result = '0;
    x_rf_psrc1_value = '0; x_rf_psrc2_value = '0;

    repeat (2) @(negedge clk);
    chk("reset_pipe_vld", {63'd0, pipe_vld}, 64'd0);
    chk("reset_rdy", {63'd0, idu_rf_rdy}, 64'd1);
    chk("reset_pc", pipe_pc, 64'd0);

    cyc();
    rst_clk = 1'b1;
    set_uop(5'd3, 1'b1, 6'd5, 1'b0, 6'd7, 64'h1000);
    idu_rf_vld = 1'b1;
    x_rf_psrc1_value = 64'h11; x_rf_psrc2_value = 64'h22;
    cyc();
    idu_rf_vld = 1'b0;
    @(negedge clk);
    chk("accept_vld", {63'd0, pipe_vld}, 64'd1);
    chk("accept_iid", XL'(pipe_iid), 64'd3);
    chk("accept_rf_op1", pipe_psrc1_value, 64'h11);

    cyc();
    set_port(0, 6'd5, 64'hA0);
    set_port(1, 6'd7, 64'hBB);
    set_port(3, 6'd5, 64'hD3);
    fwd_vld = 8'b0000_1011;
    @(negedge clk);
    chk("fwd_priority", pipe_psrc1_value, 64'hA0);
    chk("psrc2_novld_rf", pipe_psrc2_value, 64'h22);

    cyc();
    fwd_vld = '0;
    ex_rf_rdy = 1'b1;
    idu_rf_vld = 1'b1;
    set_uop(5'd4, 1'b1, 6'd9, 1'b1, 6'd3, 64'h2000);
    x_rf_psrc1_value = 64'h55;
    cyc();
    idu_rf_vld = 1'b0; ex_rf_rdy = 1'b0;
    set_port(2, 6'd9, 64'h77);
    fwd_vld = 8'b0000_0100;
    @(negedge clk);
    chk("b2b_iid", XL'(pipe_iid), 64'd4);
    chk("fwd_port2", pipe_psrc1_value, 64'h77);

    cyc();
    fwd_vld = '0;
    x_rf_psrc1_value = 64'h0;
    @(negedge clk);
    chk("capture_hold", pipe_psrc1_value, CAP ? 64'h77 : 64'h0);

    cyc();
    idu_rf_vld = 1'b1;
    set_uop(5'd6, 1'b1, 6'd12, 1'b0, 6'd0, 64'h3000);
    @(negedge clk);
    chk("hold_rdy", {63'd0, idu_rf_rdy}, 64'd0);
    chk("hold_iid", XL'(pipe_iid), 64'd4);
    chk("hold_pc", pipe_pc, 64'h2000);
    chk("capture_hold2", pipe_psrc1_value, CAP ? 64'h77 : 64'h0);

    cyc();
    ex_rf_rdy = 1'b1;
    cyc();
    idu_rf_vld = 1'b0; ex_rf_rdy = 1'b0;
    x_rf_psrc1_value = 64'h33;
    @(negedge clk);
    chk("replace_vld", {63'd0, pipe_vld}, 64'd1);
    chk("replace_iid", XL'(pipe_iid), 64'd6);
    chk("replace_op1", pipe_psrc1_value, 64'h33);

    cyc();
    rtu_global_flush = 1'b1; idu_rf_vld = 1'b1; ex_rf_rdy = 1'b1;
    set_uop(5'd9, 1'b1, 6'd1, 1'b1, 6'd2, 64'hDEAD);
    cyc();
    rtu_global_flush = 1'b0; idu_rf_vld = 1'b0; ex_rf_rdy = 1'b0;
    @(negedge clk);
    chk("flush_vld", {63'd0, pipe_vld}, 64'd0);
    chk("flush_iid", XL'(pipe_iid), 64'd0);
    chk("flush_pc", pipe_pc, 64'd0);
    chk("flush_preg1", XL'(x_rf_preg_psrc1), 64'd0);

    for (int n = 0; n < 2000; n++) begin
      cyc();
      rtu_global_flush = ($urandom_range(0, 99) < 3);
      idu_rf_vld = $urandom_range(0, 1);
      ex_rf_rdy = ($urandom_range(0, 9) < 6);
      idu_rf_iid = IW'($urandom); idu_rf_opcode = 7'($urandom);
      idu_rf_funct7 = 7'($urandom); idu_rf_funct3 = 3'($urandom);
      idu_rf_pc = {$urandom, $urandom}; idu_rf_imm = {$urandom, $urandom};
      idu_rf_psrc1_vld = ($urandom_range(0, 3) != 0); idu_rf_psrc1 = PW'($urandom_range(0, 7));
      idu_rf_psrc2_vld = ($urandom_range(0, 3) != 0); idu_rf_psrc2 = PW'($urandom_range(0, 7));
      idu_rf_pdst_vld = $urandom_range(0, 1); idu_rf_pdst = PW'($urandom);
      idu_rf_imm_vld = $urandom_range(0, 1);
      fwd_vld = FN'($urandom);
      for (int j = 0; j < FN; j++) set_port(j, PW'($urandom_range(0, 7)), {$urandom, $urandom});
      x_rf_psrc1_value = {$urandom, $urandom};
      x_rf_psrc2_value = {$urandom, $urandom};
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/idu_rf_pipex.md
# idu_rf_pipex

Parametrised register-read stage for one issue pipe; successor to the fixed per-pipe RF stages. Latches the issued uop, drives physical-register read addresses to the regfile, and resolves both source operands. Operands come from regfile data or from FWD_NUM bypass ports, and the lowest-indexed matching port wins. Adds a valid/ready handshake toward EX and, optionally, capture of bypassed operands while the stage is stalled.

## Interface
Parameters:
- XLEN, 64, operand/pc/imm width
- PREG_W, 6, physical register index width
- IID_W, 5, instruction id width
- FWD_NUM, 8, bypass port count; index 0 = highest priority (EX ports first, then CDB ports)

Ports:
- clk  in  1  clock; one clock domain
- rst_clk  in  1  asynchronous active-low reset
- rtu_global_flush  in  1  kill stage contents
- idu_rf_vld  in  1  uop offered by issue
- idu_rf_rdy  out  1  stage can accept; = !pipe_vld | ex_rf_rdy
- idu_rf_iid / opcode / funct7 / funct3 / pc  in  IID_W/7/7/3/XLEN  uop fields
- idu_rf_psrc1_vld, idu_rf_psrc1, idu_rf_psrc2_vld, idu_rf_psrc2  in  1/PREG_W each  sources
- idu_rf_pdst_vld, idu_rf_pdst, idu_rf_imm_vld, idu_rf_imm  in  1/PREG_W/1/XLEN  dest, immediate
- fwd_vld  in  FWD_NUM  bypass valid per port
- fwd_preg  in  FWD_NUM*PREG_W  bypass tag, port k at [k*PREG_W +: PREG_W]
- fwd_result  in  FWD_NUM*XLEN  bypass data, port k at [k*XLEN +: XLEN]
- x_rf_preg_psrc1_vld, x_rf_preg_psrc1, x_rf_preg_psrc2_vld, x_rf_preg_psrc2  out  1/PREG_W  regfile read ports (registered)
- x_rf_psrc1_value, x_rf_psrc2_value  in  XLEN  regfile read data, same cycle
- ex_rf_rdy  in  1  EX consumes pipe contents this cycle
- pipe_vld, pipe_iid, pipe_opcode, pipe_funct7, pipe_funct3, pipe_pc  out  uop to EX
- pipe_psrc1_vld, pipe_psrc1_value, pipe_psrc2_vld, pipe_psrc2_value  out  1/XLEN  resolved operands
- pipe_pdst_vld, pipe_pdst, pipe_imm_vld, pipe_imm  out  dest, immediate

## Operation
- Accept = idu_rf_vld & idu_rf_rdy: all uop fields are loaded into registers and pipe_vld is set to 1.
- Issue = pipe_vld & ex_rf_rdy. With issue and no new accept, pipe_vld clears and all payload registers return to 0.
- Hold = pipe_vld & !ex_rf_rdy: all registers keep their values and idu_rf_rdy = 0.
- Operand k resolution, combinational, evaluated in this order:
  - cap_vld[k] set: cap_val[k].
  - psrc_vld & any port j with fwd_vld[j] & fwd_preg[j]==psrc: fwd_result of the lowest such j.
  - otherwise: x_rf_psrcN_value.
- pipe_psrcN_vld equals x_rf_preg_psrcN_vld.
- Flush has priority over accept, issue and hold. At the next edge, all registers and capture state clear to 0, and any uop accepted in that same cycle is discarded.

## Timing
- Reset (async, rst_clk low): every registered output is 0, cap_vld = 0, cap_val = 0, and idu_rf_rdy = 1.
- Latency: a uop accepted at edge N is visible on pipe_* from cycle N+1. Operand values are valid in the same cycle as the read addresses.
- Back-to-back: accept and issue in the same cycle replaces the contents with no bubble.
- Bypass data must be sampled in the cycle it is valid; no port is delayed inside this block.
- Simultaneous matches on several ports: strict priority to the lowest index. Matches are never OR-merged.
- psrc_vld = 0 ignores all bypass matches and passes regfile data through.

## Configuration
- RF_PIPE_FWD_CAPTURE_EN defined:
  - At a hold edge, each operand with psrc_vld, no cap_vld, and a bypass match sets cap_vld[k] and loads cap_val[k] with the selected fwd_result.
  - cap_vld clears on issue, accept or flush.
- Undefined: cap_vld/cap_val are not built, and operands re-resolve every cycle from regfile and bypass.

## Structure
- Package idu_rf_pkg holds the default constants XLEN_D, PREG_W_D, IID_W_D and FWD_NUM_D.
- Sub-module idu_rf_fwd_sel is the priority match-and-select for one operand (FWD_NUM ports in; hit and value out). It is instantiated twice.
- The capture registers and the handshake logic live in the top module.

## Test plan
- Reset, then accept a uop with iid 3 and psrc1 = 5 while the regfile returns 0x11 → next cycle pipe_vld = 1, pipe_iid = 3, psrc1_value = 0x11.
- fwd_vld = 0b1001 with ports 0 and 3 both tagged 5 (values 0xA0 / 0xD3) → psrc1_value = 0xA0.
- psrc2_vld = 0 with port 1 tagged equal to psrc2 → psrc2_value equals regfile data.
- With capture enabled: ex_rf_rdy = 0, port 2 supplies 0x77 for preg 9 for one cycle, then the regfile returns 0 → psrc1_value stays 0x77 until issue. With capture disabled, the value drops to 0.
- Hold with idu_rf_vld = 1 → idu_rf_rdy = 0 and the payload is unchanged. Raising ex_rf_rdy gives issue plus accept in the same cycle, and the new iid appears next cycle with no bubble.
- rtu_global_flush asserted during an accept → next cycle pipe_vld = 0, all outputs 0, and the accepted uop is lost.
